// File: rtl/alu_seq.sv
// alu_seq: multicycle ALU with a start/busy/done handshake.
// Single-cycle ops finish in EXEC, shifts iterate SHIFT_STEP bits per cycle,
// and an optional shift-add multiplier is built when ALU_SEQ_MUL_EN is defined.
// Results (ALUResult, Zero) are registered on DONE entry and held afterwards.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [9:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic             Zero,
  output logic [WIDTH-1:0] ALUResult
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP    = (SHW+1)'(SHIFT_STEP);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

  localparam logic [9:0] OP_ADD  = 10'h000;
  localparam logic [9:0] OP_SUB  = 10'h100;
  localparam logic [9:0] OP_SLL  = 10'h001;
  localparam logic [9:0] OP_SLT  = 10'h002;
  localparam logic [9:0] OP_SLTU = 10'h003;
  localparam logic [9:0] OP_XOR  = 10'h004;
  localparam logic [9:0] OP_SRL  = 10'h005;
  localparam logic [9:0] OP_SRA  = 10'h105;
  localparam logic [9:0] OP_OR   = 10'h006;
  localparam logic [9:0] OP_AND  = 10'h007;
  localparam logic [9:0] OP_BEQ  = 10'h008;
  localparam logic [9:0] OP_BNE  = 10'h009;
  localparam logic [9:0] OP_BLT  = 10'h00A;
  localparam logic [9:0] OP_BGE  = 10'h00B;
  localparam logic [9:0] OP_BLTU = 10'h00C;
  localparam logic [9:0] OP_BGEU = 10'h00D;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [9:0] OP_MUL  = 10'h010;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_DONE
`ifdef ALU_SEQ_MUL_EN
    , S_MUL
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;      // latched operands; a_q doubles as shift accumulator
  logic [9:0]       op_q;
  logic [SHW:0]     cnt_q;         // shift: bits remaining; MUL: iterations done
  logic [SHW:0]     amt;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] exec_res;
  logic             exec_zero;
  logic [WIDTH-1:0] diff;
  logic             lt_s, lt_u;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] prod_q;
`endif

  function automatic logic is_shift(input logic [9:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking = here would create order-dependent races.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_shift(ALUControl))       state_d = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
          else if (ALUControl == OP_MUL)  state_d = S_MUL;
`endif
          else                            state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_DONE;
      S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
`ifdef ALU_SEQ_MUL_EN
      S_MUL:   if (cnt_q == CNT_MUL) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle result and branch condition from the latched operands.
  always_comb begin
    diff      = a_q - b_q;
    lt_s      = $signed(a_q) < $signed(b_q);
    lt_u      = a_q < b_q;
    exec_res  = '0;
    exec_zero = 1'b0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = diff;
      OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: exec_res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_BEQ:  begin exec_res = diff; exec_zero = (a_q == b_q); end
      OP_BNE:  begin exec_res = diff; exec_zero = (a_q != b_q); end
      OP_BLT:  begin exec_res = diff; exec_zero = lt_s;        end
      OP_BGE:  begin exec_res = diff; exec_zero = !lt_s;       end
      OP_BLTU: begin exec_res = diff; exec_zero = lt_u;        end
      OP_BGEU: begin exec_res = diff; exec_zero = !lt_u;       end
      default: ;
    endcase
  end

  // One shift step: up to SHIFT_STEP bits, never past the remaining amount.
  always_comb begin
    amt       = (cnt_q >= STEP) ? STEP : cnt_q;
    shift_out = a_q;
    case (op_q)
      OP_SLL:  shift_out = a_q << amt;
      OP_SRL:  shift_out = a_q >> amt;
      OP_SRA:  shift_out = $signed(a_q) >>> amt;
      default: ;
    endcase
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge clk) begin
    // NOTE: operand/iteration registers carry no reset; they are always
    // reloaded at accept before being read, and the FSM alone defines validity.
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_q   <= srcA;
          b_q   <= srcB;
          op_q  <= ALUControl;
          cnt_q <= is_shift(ALUControl) ? {1'b0, srcB[SHW-1:0]} : '0;
`ifdef ALU_SEQ_MUL_EN
          prod_q <= '0;
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          a_q   <= shift_out;
          cnt_q <= cnt_q - amt;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (cnt_q != CNT_MUL) begin
          if (b_q[0]) prod_q <= prod_q + a_q;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + (SHW+1)'(1);
        end
      end
`endif
      default: ;
    endcase
  end

  // Result/Zero registers: loaded on DONE entry, held otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      case (state_q)
        S_EXEC: begin
          ALUResult <= exec_res;
          Zero      <= exec_zero;
        end
        S_SHIFT: begin
          if (cnt_q == '0) begin
            ALUResult <= a_q;
            Zero      <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          if (cnt_q == CNT_MUL) begin
            ALUResult <= prod_q;
            Zero      <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
